// File: rtl/operand_arbiter_if.sv
// Request, datapath and response signals of the shared-datapath arbiter.
// The arbiter takes the slave side; the requesters/datapath sit on master.
interface operand_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic                          en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          dp_valid;
  logic [DATA_WIDTH-1:0]         dp_a;
  logic [DATA_WIDTH-1:0]         dp_b;
  logic [DATA_WIDTH-1:0]         dp_result;
  logic                          rsp_valid;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          idle;

  modport master (
    output en, req_valid, req_a, req_b, dp_result,
    input  req_ready, dp_valid, dp_a, dp_b,
    input  rsp_valid, rsp_id, rsp_data, idle
  );

  modport slave (
    input  en, req_valid, req_a, req_b, dp_result,
    output req_ready, dp_valid, dp_a, dp_b,
    output rsp_valid, rsp_id, rsp_data, idle
  );
endinterface

// File: rtl/operand_arbiter.sv
// Round-robin issue of operand pairs into one fixed-latency datapath,
// with per-issue ID tags so each result returns to its requester.
module operand_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  operand_arbiter_if.slave bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int TD  = DP_LATENCY + 1;
  localparam int CW  = $clog2(DP_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           dp_valid_q;
  logic [DW-1:0]  dp_a_q, dp_a_d;
  logic [DW-1:0]  dp_b_q, dp_b_d;

  logic [TD-1:0]  tag_v_q;
  logic [IDW-1:0] tag_id_q [TD];

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [DW-1:0]  rsp_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_id;
  logic               accept;
  logic               retire;

  // First valid requester at or above ptr, wrapping; gated by en same cycle
  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    gnt_id = '0;
    accept = 1'b0;
    if (state_q == RUN && bus.en) begin
      for (int o = 0; o < NUM_REQ; o++) begin
        idx = (int'(ptr_q) + o) % NUM_REQ;
        if (!accept && bus.req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_id     = IDW'(idx);
          accept     = 1'b1;
        end
      end
    end
  end

  assign retire = tag_v_q[TD-1];

  always_comb begin
    ptr_d  = ptr_q;
    dp_a_d = dp_a_q;
    dp_b_d = dp_b_q;
    if (accept) begin
      if (gnt_id == IDW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_id + IDW'(1);
      end
      dp_a_d = bus.req_a[gnt_id*DW +: DW];
      dp_b_d = bus.req_b[gnt_id*DW +: DW];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, retire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        if (!bus.en) begin
          state_d = (cnt_q != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (bus.en) begin
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      dp_valid_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      tag_v_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      for (int j = 0; j < TD; j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= accept;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      tag_v_q     <= {tag_v_q[TD-2:0], accept};
      tag_id_q[0] <= gnt_id;
      for (int j = 1; j < TD; j++) begin
        tag_id_q[j] <= tag_id_q[j-1];
      end
      // Last tag stage lines up with the result on dp_result
      rsp_valid_q <= retire;
      if (retire) begin
        rsp_id_q   <= tag_id_q[TD-1];
        rsp_data_q <= bus.dp_result;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.idle      = (state_q == IDLE);
endmodule

// File: tb/tb_operand_arbiter.sv
// Scoreboard bench: random requests, a delay-line datapath model and
// queued expectations popped by an independent negedge monitor.
module tb_operand_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int L  = 2;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
    int         due;
  } rsp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         due;
  } dp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  rsp_t rq[$];
  dp_t  dq[$];

  bit         running = 1'b0;
  bit         exp_idle = 1'b1;
  int         ptr = 0;
  logic [N-1:0] exp_ready = '0;
  logic [7:0] a_in [N];
  logic [7:0] b_in [N];
  logic [7:0] dpp [L];

  operand_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  operand_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(N),
    .DP_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dpf(logic [7:0] a, logic [7:0] b);
    logic [7:0] t;
    t = a * 8'd3;
    return t ^ b;
  endfunction

  // Datapath stand-in: result of the pair issued L cycles earlier
  always @(posedge clk) begin
    dpp[0] <= dpf(bus.dp_a, bus.dp_b);
    for (int j = 1; j < L; j++) dpp[j] <= dpp[j-1];
  end
  assign bus.dp_result = dpp[L-1];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i] = 8'($urandom);
      b_in[i] = 8'($urandom);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of it
  task automatic step(input bit r, input bit e, input logic [N-1:0] v);
    int gid;
    int infl;
    bit acc;
    bit idle_nx;
    int ptr_nx;
    rst           = r;
    bus.en        = e;
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = a_in[i];
      bus.req_b[i*DW +: DW] = b_in[i];
    end
    gid = 0;
    acc = 1'b0;
    if (running && e) begin
      for (int o = 0; o < N; o++) begin
        if (!acc && v[(ptr + o) % N]) begin
          gid = (ptr + o) % N;
          acc = 1'b1;
        end
      end
    end
    exp_ready = '0;
    if (acc) exp_ready[gid] = 1'b1;
    infl = 0;
    foreach (rq[k]) if (rq[k].due > cyc) infl++;
    ptr_nx = ptr;
    if (acc && !r) begin
      dq.push_back('{a_in[gid], b_in[gid], cyc + 1});
      rq.push_back('{2'(gid), dpf(a_in[gid], b_in[gid]), cyc + L + 2});
      ptr_nx = (gid + 1) % N;
    end
    idle_nx = !e && (exp_idle || infl == 0);
    @(posedge clk);
    #1;
    if (r) begin
      rq.delete();
      dq.delete();
      ptr      = 0;
      running  = 1'b0;
      exp_idle = 1'b1;
    end else begin
      ptr      = ptr_nx;
      running  = e;
      exp_idle = idle_nx;
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("idle", 32'(bus.idle), 32'(exp_idle));
      if (bus.dp_valid) begin
        chk("dp_due", 32'(cyc), (dq.size() != 0) ? 32'(dq[0].due) : '1);
        if (dq.size() != 0 && dq[0].due == cyc) begin
          chk("dp_a", 32'(bus.dp_a), 32'(dq[0].a));
          chk("dp_b", 32'(bus.dp_b), 32'(dq[0].b));
          void'(dq.pop_front());
        end
      end else if (dq.size() != 0 && dq[0].due <= cyc) begin
        chk("dp_valid", 32'(bus.dp_valid), 32'd1);
        void'(dq.pop_front());
      end
      if (bus.rsp_valid) begin
        chk("rsp_due", 32'(cyc), (rq.size() != 0) ? 32'(rq[0].due) : '1);
        if (rq.size() != 0 && rq[0].due == cyc) begin
          chk("rsp_id", 32'(bus.rsp_id), 32'(rq[0].id));
          chk("rsp_data", 32'(bus.rsp_data), 32'(rq[0].d));
          void'(rq.pop_front());
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    rand_ops();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("reset_outputs",
        {bus.req_ready, bus.dp_valid, bus.rsp_valid, bus.rsp_id,
         bus.rsp_data, bus.dp_a, bus.dp_b}, 32'd0);
    chk("reset_idle", 32'(bus.idle), 32'd1);
    mon_on = 1'b1;

    // Single request from requester 1
    step(1'b0, 1'b1, '0);
    a_in[1] = 8'h12;
    b_in[1] = 8'h34;
    step(1'b0, 1'b1, 4'b0010);
    repeat (6) step(1'b0, 1'b1, '0);

    // All requesters busy: strict rotation, one issue per cycle
    repeat (20) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b1111);
    end

    // Only 2 and 3 competing
    repeat (12) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b1100);
    end

    // en drops with requests pending: drain, then resume
    repeat (4) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b1111);
    end
    repeat (8) step(1'b0, 1'b0, 4'b1111);
    repeat (6) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b0111);
    end

    // Reset while results are in flight
    repeat (3) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b1111);
    end
    step(1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, '0);
    repeat (4) begin
      rand_ops();
      step(1'b0, 1'b1, 4'b1010);
    end

    // Random mix including dropped requests and occasional reset
    repeat (400) begin
      rand_ops();
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 7) != 0),
           4'($urandom));
    end

    repeat (10) step(1'b0, 1'b0, '0);
    chk("rsp_left", 32'(rq.size()), 32'd0);
    chk("dp_left", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
